fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 7 +
 rtl/fetch_timer.sv | 20 ++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, timer sizing and fetch FSM state encodings.
package cpu_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;
  localparam int TIMER_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN, ST_HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts memory wait cycles and flags the cycle the limit is reached.
module fetch_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + TIMER_W'(1) : cnt_q;
  // Fires on the wait cycle whose increment would reach TIMEOUT.
  assign expired_o = enable_i && !clear_i && cnt_q == TIMER_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with flush, hold and timeout.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flush,
  output logic              fetch_err
);
  fetch_state_e      state_q;
  logic              mem_req_q, instr_valid_q, fetch_err_q;
  logic [ADDR_W-1:0] mem_addr_q, instr_pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              accept, busy, expired;
  assign pc_ready = !flush && (state_q == ST_IDLE || (state_q == ST_HOLD && instr_ready));
  assign accept   = pc_valid && pc_ready;
  assign busy     = state_q == ST_REQ || state_q == ST_DRAIN;
  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (accept),
    .enable_i (busy && !mem_ack),
    .expired_o(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      fetch_err_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (accept) begin
            mem_addr_q <= pc_addr;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REQ;
          end
        ST_REQ:
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (flush) state_q <= ST_IDLE;
            else begin
              instr_q       <= mem_rdata;
              instr_pc_q    <= mem_addr_q;
              instr_valid_q <= 1'b1;
              state_q       <= ST_HOLD;
            end
          end else if (expired) begin
            mem_req_q   <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (flush) state_q <= ST_DRAIN;
        // The flushed request stays on the bus until memory answers; its data is dropped.
        ST_DRAIN:
          if (mem_ack || expired) begin
            mem_req_q   <= 1'b0;
            fetch_err_q <= !mem_ack;
            state_q     <= ST_IDLE;
          end
        ST_HOLD:
          if (flush || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
            if (accept) begin
              mem_addr_q <= pc_addr;
              mem_req_q  <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed per-cycle vectors plus reset and timeout sequences.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic        fetch_err;
  int checks = 0;
  int errors = 0;
  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc_addr),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .flush      (flush),
    .fetch_err  (fetch_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic        pv;
    logic [11:0] pa;
    logic        ack;
    logic [15:0] rd;
    logic        ir;
    logic        fl;
    logic        e_prdy;
    logic        e_req;
    logic [11:0] e_addr;
    logic        e_iv;
    logic [15:0] e_instr;
    logic [11:0] e_ipc;
    logic        e_err;
  } vec_t;
  vec_t vecs[20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic pv, input logic [11:0] pa, input logic ack, input logic [15:0] rd,
                       input logic ir, input logic fl);
    pc_valid = pv; pc_addr = pa; mem_ack = ack; mem_rdata = rd; instr_ready = ir; flush = fl;
  endtask
  task automatic chk_all(input string tag, input logic prdy, input logic req, input logic [11:0] addr,
                         input logic iv, input logic [15:0] ins, input logic [11:0] ipc, input logic err);
    chk({tag, ".pc_ready"}, 32'(pc_ready), 32'(prdy));
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(req));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
    chk({tag, ".instr"}, 32'(instr), 32'(ins));
    chk({tag, ".instr_pc"}, 32'(instr_pc), 32'(ipc));
    chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(err));
  endtask
  initial begin
    //            pv  pa      ack rd        ir  fl   prdy req addr    iv  instr     ipc     err
    vecs[0]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000, 1'b0};
    vecs[1]  = '{1'b1, 12'h00A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 12'h00A, 1'b0, 16'h0000, 12'h000, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00A, 1'b1, 16'hBEEF, 12'h00A, 1'b0};
    vecs[4]  = '{1'b0, 12'h000, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00A, 1'b1, 16'hBEEF, 12'h00A, 1'b0};
    vecs[5]  = '{1'b1, 12'h00B, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00A, 1'b1, 16'hBEEF, 12'h00A, 1'b0};
    vecs[6]  = '{1'b1, 12'h00B, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00A, 1'b1, 16'hBEEF, 12'h00A, 1'b0};
    vecs[7]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00A, 1'b1, 16'hBEEF, 12'h00A, 1'b0};
    vecs[8]  = '{1'b1, 12'h00B, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h00A, 1'b1, 16'hBEEF, 12'h00A, 1'b0};
    vecs[9]  = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 12'h00B, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[10] = '{1'b1, 12'h0FF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h00B, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[11] = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h00B, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[12] = '{1'b0, 12'h000, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 12'h00B, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[13] = '{1'b1, 12'h055, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h00B, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[14] = '{1'b1, 12'h123, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00B, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[15] = '{1'b0, 12'h000, 1'b1, 16'hCAFE, 1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[16] = '{1'b1, 12'h200, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[17] = '{1'b0, 12'h000, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 12'h200, 1'b0, 16'hBEEF, 12'h00A, 1'b0};
    vecs[18] = '{1'b1, 12'h300, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h200, 1'b1, 16'h1111, 12'h200, 1'b0};
    vecs[19] = '{1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h200, 1'b0, 16'h1111, 12'h200, 1'b0};
    rst_n = 1'b0;
    drive(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_all("reset", 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].pa, vecs[i].ack, vecs[i].rd, vecs[i].ir, vecs[i].fl);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_prdy, vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_iv, vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_err);
    end
    // Reset while a fetch is outstanding; a late ack must not revive it.
    @(negedge clk);
    drive(1'b1, 12'h0CC, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 chk("rst_mid.accept", 32'(pc_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 chk("rst_mid.req", 32'(mem_req), 32'd1);
    chk("rst_mid.addr", 32'(mem_addr), 32'h0CC);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_mid.async", 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 12'h000, 1'b1, 16'h7777, 1'b0, 1'b0);
    #1 chk("rst_rel.pc_ready", 32'(pc_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 chk_all("rst_rel.after", 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000, 1'b0);
    // Timeout: request held for 15 cycles, then fetch_err pulses once.
    @(negedge clk);
    drive(1'b1, 12'h0AB, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 chk("to.accept", 32'(pc_ready), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      drive(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      chk($sformatf("to.c%0d.mem_req", k), 32'(mem_req), (k <= 15) ? 32'd1 : 32'd0);
      chk($sformatf("to.c%0d.fetch_err", k), 32'(fetch_err), (k == 16) ? 32'd1 : 32'd0);
    end
    chk("to.instr_valid", 32'(instr_valid), 32'd0);
    chk("to.pc_ready", 32'(pc_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
